// File: rtl/score_award_sequencer.sv
// Score award sequencer: turns binary point awards into a paced train of
// single-cycle increment pulses for the BCD score counter, accumulating
// overlapping awards and saturating at the display maximum.
module score_award_sequencer #(
    parameter int unsigned SCORE_DIGITS  = 6,
    parameter int unsigned MAX_SCORE     = 999999,
    parameter int unsigned TALLY_WIDTH   = 20,
    parameter int unsigned POINTS_WIDTH  = 8,
    parameter int unsigned PENDING_WIDTH = 12,
    parameter int unsigned ENABLE_GAP    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     award_valid,
    input  logic [POINTS_WIDTH-1:0]  award_points,
    output logic                     award_ready,
    input  logic                     count_ready,
    output logic                     count_enable,
    output logic [PENDING_WIDTH-1:0] pending,
    output logic [TALLY_WIDTH-1:0]   tally,
    output logic                     busy,
    output logic                     saturated,
    output logic                     overflow
);

    // Never let the tally run past all-9s on the display, even if MAX_SCORE is mis-set.
    localparam int unsigned DigitsMax = (10 ** SCORE_DIGITS) - 1;
    localparam int unsigned MaxScore  = (MAX_SCORE < DigitsMax) ? MAX_SCORE : DigitsMax;
    localparam int unsigned SumW      =
        ((PENDING_WIDTH > POINTS_WIDTH) ? PENDING_WIDTH : POINTS_WIDTH) + 1;
    localparam int unsigned PendMax   = (2 ** PENDING_WIDTH) - 1;
    localparam int unsigned GapW      = (ENABLE_GAP > 1) ? $clog2(ENABLE_GAP) : 1;

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e                   state_q, state_d;
    logic [GapW-1:0]          gap_q, gap_d;
    logic [PENDING_WIDTH-1:0] pending_q, pending_d;
    logic [TALLY_WIDTH-1:0]   tally_q, tally_d;
    logic                     sat_q, sat_d;
    logic                     ovf_q, ovf_d;
    logic                     en_q, en_d;
    logic                     award_ready_q, award_ready_d;

    logic                     accept;
    logic                     in_pulse;
    logic [SumW-1:0]          sum;
    logic [TALLY_WIDTH-1:0]   tally_inc;

    // Next-state: accumulation, pulse bookkeeping, saturation and FSM sequencing.
    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        pending_d     = pending_q;
        tally_d       = tally_q;
        sat_d         = sat_q;
        ovf_d         = ovf_q;
        en_d          = 1'b0;
        award_ready_d = 1'b1;

        accept    = award_valid && award_ready_q;
        in_pulse  = (state_q == StPulse);
        tally_inc = tally_q + TALLY_WIDTH'(1);

        // Award and the pulse's own decrement net out in a single update.
        sum = SumW'(pending_q) + (accept ? SumW'(award_points) : SumW'(0)) - SumW'(in_pulse);

        if (sat_q) begin
            pending_d = '0;
            if (accept && (award_points != '0)) begin
                ovf_d = 1'b1;
            end
        end else if (sum > SumW'(PendMax)) begin
            pending_d = PENDING_WIDTH'(PendMax);
            ovf_d     = 1'b1;
        end else begin
            pending_d = sum[PENDING_WIDTH-1:0];
        end

        if (in_pulse) begin
            tally_d = tally_inc;
            // Reaching the display maximum discards whatever is still owed.
            if (tally_inc == TALLY_WIDTH'(MaxScore)) begin
                sat_d = 1'b1;
                if (pending_d != '0) begin
                    ovf_d = 1'b1;
                end
                pending_d = '0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if ((pending_q != '0) && !sat_q && count_ready) begin
                    state_d = StPulse;
                    en_d    = 1'b1;
                end
            end
            StPulse: begin
                state_d = StGap;
                gap_d   = '0;
            end
            StGap: begin
                // count_ready is deliberately ignored here to let the counter settle.
                if (gap_q == GapW'(ENABLE_GAP - 1)) begin
                    state_d = StIdle;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                gap_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StIdle;
            gap_q         <= '0;
            pending_q     <= '0;
            tally_q       <= '0;
            sat_q         <= 1'b0;
            ovf_q         <= 1'b0;
            en_q          <= 1'b0;
            award_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            pending_q     <= pending_d;
            tally_q       <= tally_d;
            sat_q         <= sat_d;
            ovf_q         <= ovf_d;
            en_q          <= en_d;
            award_ready_q <= award_ready_d;
        end
    end

    assign award_ready  = award_ready_q;
    assign count_enable = en_q;
    assign pending      = pending_q;
    assign tally        = tally_q;
    assign saturated    = sat_q;
    assign overflow     = ovf_q;
    assign busy         = (pending_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_score_award_sequencer.sv
// Directed bench for score_award_sequencer: a default-configured instance plus a
// small one (single digit, 4-bit pending) for saturation and clipping.
module tb_score_award_sequencer;

    logic clk = 1'b0;
    logic reset;

    logic        a_valid, a_cready, a_ready, a_en, a_busy, a_sat, a_ovf;
    logic [7:0]  a_points;
    logic [11:0] a_pending;
    logic [19:0] a_tally;

    logic        b_valid, b_cready, b_ready, b_en, b_busy, b_sat, b_ovf;
    logic [7:0]  b_points;
    logic [3:0]  b_pending;
    logic [3:0]  b_tally;

    int passed = 0;
    int total  = 0;
    int pulses;

    always #5 clk = ~clk;

    score_award_sequencer dut_a (
        .clock        (clk),
        .reset        (reset),
        .award_valid  (a_valid),
        .award_points (a_points),
        .award_ready  (a_ready),
        .count_ready  (a_cready),
        .count_enable (a_en),
        .pending      (a_pending),
        .tally        (a_tally),
        .busy         (a_busy),
        .saturated    (a_sat),
        .overflow     (a_ovf)
    );

    score_award_sequencer #(
        .SCORE_DIGITS  (1),
        .MAX_SCORE     (9),
        .TALLY_WIDTH   (4),
        .POINTS_WIDTH  (8),
        .PENDING_WIDTH (4),
        .ENABLE_GAP    (1)
    ) dut_b (
        .clock        (clk),
        .reset        (reset),
        .award_valid  (b_valid),
        .award_points (b_points),
        .award_ready  (b_ready),
        .count_ready  (b_cready),
        .count_enable (b_en),
        .pending      (b_pending),
        .tally        (b_tally),
        .busy         (b_busy),
        .saturated    (b_sat),
        .overflow     (b_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    initial begin
        reset    = 1'b0;
        a_valid  = 1'b0;
        a_points = 8'd0;
        a_cready = 1'b1;
        b_valid  = 1'b0;
        b_points = 8'd0;
        b_cready = 1'b1;

        // Reset held three cycles: everything low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_award_ready", a_ready, 0);
            check("rst_en", a_en, 0);
            check("rst_pending", a_pending, 0);
            check("rst_tally", a_tally, 0);
            check("rst_busy", a_busy, 0);
            check("rst_sat", a_sat, 0);
            check("rst_ovf", a_ovf, 0);
            check("rst_b_ready", b_ready, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rel_award_ready", a_ready, 1);
        check("rel_b_ready", b_ready, 1);
        check("rel_en", a_en, 0);

        // Zero-point award is accepted and does nothing.
        a_valid  = 1'b1;
        a_points = 8'd0;
        @(negedge clk);
        a_valid = 1'b0;
        check("zero_pending", a_pending, 0);
        check("zero_busy", a_busy, 0);
        check("zero_en", a_en, 0);

        // Award 5: pulses at T+2, T+5, ... T+14; busy clears after the last gap.
        a_valid  = 1'b1;
        a_points = 8'd5;
        pulses   = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_valid = 1'b0;
                check("t2_pending_t1", a_pending, 5);
            end
            check($sformatf("t2_en_c%0d", c), a_en, (c >= 2 && c <= 14 && (c - 2) % 3 == 0));
            if (a_en) pulses++;
            if (c == 15) check("t2_busy_gap", a_busy, 1);
            if (c == 16) check("t2_busy_idle", a_busy, 0);
        end
        check("t2_pulses", pulses, 5);
        check("t2_tally", a_tally, 5);
        check("t2_pending", a_pending, 0);

        // count_ready low stalls indefinitely.
        a_cready = 1'b0;
        a_valid  = 1'b1;
        a_points = 8'd3;
        pulses   = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) a_valid = 1'b0;
            if (a_en) pulses++;
        end
        check("t3_stall_pulses", pulses, 0);
        check("t3_stall_busy", a_busy, 1);
        check("t3_stall_pending", a_pending, 3);
        a_cready = 1'b1;
        @(negedge clk);
        check("t3_first_pulse", a_en, 1);
        pulses = 1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_en) pulses++;
        end
        check("t3_pulses", pulses, 3);
        check("t3_tally", a_tally, 8);
        check("t3_busy", a_busy, 0);

        // Award 4, then award 2 landing in the second PULSE (pending 3 -> 4).
        a_valid  = 1'b1;
        a_points = 8'd4;
        pulses   = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (a_en) pulses++;
            if (c == 1) a_valid = 1'b0;
            if (c == 5) begin
                check("t4_pulse_cycle", a_en, 1);
                check("t4_pending_before", a_pending, 3);
                a_valid  = 1'b1;
                a_points = 8'd2;
            end
            if (c == 6) begin
                a_valid = 1'b0;
                check("t4_pending_after", a_pending, 4);
            end
        end
        check("t4_pulses", pulses, 6);
        check("t4_tally", a_tally, 14);
        check("t4_ovf", a_ovf, 0);

        // Small instance: award 12 with MAX_SCORE 9 saturates on the 9th pulse.
        b_valid  = 1'b1;
        b_points = 8'd12;
        pulses   = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) b_valid = 1'b0;
            if (b_en) pulses++;
            if (c == 26) begin
                check("t5_ninth_pulse", b_en, 1);
                check("t5_sat_before", b_sat, 0);
            end
            if (c == 27) begin
                check("t5_sat", b_sat, 1);
                check("t5_pending_cleared", b_pending, 0);
                check("t5_ovf", b_ovf, 1);
                check("t5_tally", b_tally, 9);
            end
        end
        check("t5_pulses", pulses, 9);
        b_valid  = 1'b1;
        b_points = 8'd1;
        pulses   = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) b_valid = 1'b0;
            if (b_en) pulses++;
        end
        check("t5_post_sat_pulses", pulses, 0);
        check("t5_post_sat_tally", b_tally, 9);
        check("t5_post_sat_pending", b_pending, 0);

        // Reset clears sticky flags; then clip 10 + 10 into a 4-bit accumulator.
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_sat_cleared", b_sat, 0);
        check("t6_ovf_cleared", b_ovf, 0);
        check("t6_tally_cleared", b_tally, 0);
        b_cready = 1'b0;
        b_valid  = 1'b1;
        b_points = 8'd10;
        @(negedge clk);
        check("t6_pending_10", b_pending, 10);
        check("t6_ovf_none", b_ovf, 0);
        @(negedge clk);
        b_valid = 1'b0;
        check("t6_pending_clip", b_pending, 15);
        check("t6_ovf_clip", b_ovf, 1);

        // Drain, then reset in the middle of the second pulse.
        b_cready = 1'b1;
        pulses   = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (b_en) pulses++;
        end
        check("t6_second_pulse", b_en, 1);
        check("t6_pulses_before_rst", pulses, 2);
        check("t6_tally_before_rst", b_tally, 1);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_en", b_en, 0);
        check("t6_rst_tally", b_tally, 0);
        check("t6_rst_pending", b_pending, 0);
        check("t6_rst_ovf", b_ovf, 0);
        check("t6_rst_busy", b_busy, 0);
        reset  = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (b_en) pulses++;
        end
        check("t6_no_pulse_after_rst", pulses, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/score_award_sequencer.md
Name: score_award_sequencer

Overview:
- Initiator side of the score counter's enable/ready increment handshake.
- Accepts point awards as binary values from the game logic and converts each award into a train of single-cycle increment pulses toward the BCD score counter.
- Paces the pulses against the counter's ready signal, accumulates awards that overlap, tracks the running total and saturates at the display maximum.
- Sits between the game-state logic and the score counter / 7-segment display path.

Parameters:
- SCORE_DIGITS, 6: BCD digits on the display.
- MAX_SCORE, 999999: highest displayable score; must equal 10^SCORE_DIGITS - 1.
- TALLY_WIDTH, 20: width of the issued-increment tally; must satisfy 2^TALLY_WIDTH > MAX_SCORE.
- POINTS_WIDTH, 8: width of one award value.
- PENDING_WIDTH, 12: width of the pending-increment accumulator.
- ENABLE_GAP, 1: guard cycles after each pulse before count_ready is sampled again; minimum 1.

Ports:
- clock, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-low reset.
- award_valid, input, 1: award_points is valid this cycle.
- award_points, input, POINTS_WIDTH: points to add.
- award_ready, output, 1: award accepted when award_valid and award_ready are both 1.
- count_ready, input, 1: counter idle and able to take an increment.
- count_enable, output, 1: one-cycle increment request to the counter.
- pending, output, PENDING_WIDTH: increments still to issue.
- tally, output, TALLY_WIDTH: total increments issued since reset.
- busy, output, 1: high when pending != 0 or state != IDLE.
- saturated, output, 1: sticky; tally has reached MAX_SCORE.
- overflow, output, 1: sticky; award value lost to accumulator clipping or saturation.

Behaviour:
- Reset (reset=0 at an edge):
  - All outputs 0; state IDLE; gap counter 0.
  - award_ready goes 1 on the first edge with reset=1.
  - A reset mid-sequence abandons pending increments immediately; no further count_enable.
- The counter's own reset is independent and is not driven here.
- States:
  - IDLE: if pending != 0, saturated = 0 and count_ready = 1, go to PULSE.
  - PULSE: count_enable = 1 for exactly this cycle; pending decrements by 1; tally increments by 1; go to GAP.
  - GAP: count_ready is ignored; stay ENABLE_GAP cycles; then go to IDLE.
- count_enable is registered and is high only in PULSE. It is never high on two consecutive cycles.
- Latency:
  - Award accepted in cycle T with the block idle and count_ready = 1 gives the first count_enable in cycle T+2.
  - Steady-state pulse period with count_ready held high is ENABLE_GAP + 2 cycles.
  - count_ready low in IDLE stalls indefinitely with no timeout.
- Accumulation:
  - On acceptance, pending_next = pending + award_points - (1 if in PULSE this cycle).
  - Computed one bit wider than PENDING_WIDTH, then clipped to 2^PENDING_WIDTH - 1.
  - Any clipping sets overflow.
- Simultaneous award and pulse in the same cycle are both applied, net as above.
- award_points = 0 is accepted and changes nothing.
- award_ready stays 1 after reset; awards are never back-pressured.
- Saturation:
  - When a pulse brings tally to MAX_SCORE, saturated sets on that edge.
  - Remaining pending is cleared to 0 on the same edge; overflow is set if that discarded pending was nonzero.
  - While saturated, accepted awards with nonzero points set overflow and are discarded; pending stays 0.
  - tally never exceeds MAX_SCORE, and the counter never wraps past all-9s.
- saturated and overflow clear only on reset.

Test Plan:
- Reset held 3 cycles, then released: all outputs 0 during reset; award_ready = 1 one cycle after release; count_enable stays 0.
- count_ready tied 1, ENABLE_GAP = 1, award 5 at cycle T: exactly 5 count_enable pulses, first at T+2, spaced 3 cycles apart; final tally = 5, pending = 0, busy drops after the last GAP.
- count_ready held 0 for 20 cycles with award 3 pending: no pulse, busy = 1. Raise count_ready: first pulse one cycle later, all 3 pulses delivered.
- Award 4, then award 2 accepted in a PULSE cycle while pending = 3: pending becomes 4 (3 + 2 - 1); total pulses = 6; overflow = 0.
- MAX_SCORE = 9 (SCORE_DIGITS = 1), award 12: 9 pulses; saturated = 1 at the 9th pulse; pending cleared; overflow = 1. A further award 1 causes no pulse.
- PENDING_WIDTH = 4, count_ready = 0, awards 10 then 10: pending clips to 15 and overflow = 1. Assert reset mid-drain: count_enable stops within the reset edge; tally = 0.
